// File: rtl/multi_issue_scoreboard.sv
// Multi-issue in-order scoreboard: issues tracked entries, collects writebacks and retires in order.
// Optional MULTI_ISSUE_SB_WB_BYPASS_EN lets a same-cycle writeback make the head entries commit-visible.
module multi_issue_scoreboard #(
  parameter int  NR_ENTRIES = 8,
  parameter int  NR_ISSUE   = 2,
  parameter int  NR_COMMIT  = 2,
  parameter int  NR_WB      = 4,
  localparam int IDW        = $clog2(NR_ENTRIES)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic [NR_ISSUE-1:0]     issue_valid_i,
  input  logic [NR_ISSUE*5-1:0]   issue_rd_i,
  output logic [NR_ISSUE-1:0]     issue_ready_o,
  output logic [NR_ISSUE*IDW-1:0] issue_id_o,
  input  logic [NR_WB-1:0]        wb_valid_i,
  input  logic [NR_WB*IDW-1:0]    wb_id_i,
  input  logic [NR_WB-1:0]        wb_ex_i,
  output logic [NR_COMMIT-1:0]    commit_valid_o,
  output logic [NR_COMMIT*IDW-1:0] commit_id_o,
  output logic [NR_COMMIT*5-1:0]  commit_rd_o,
  output logic [NR_COMMIT-1:0]    commit_ex_o,
  input  logic [NR_COMMIT-1:0]    commit_ack_i,
  output logic [31:0]             rd_busy_o,
  output logic                    full_o,
  output logic [IDW:0]            count_o
);

  logic [NR_ENTRIES-1:0] issued_q, done_q, ex_q;
  logic [4:0]            rd_q [NR_ENTRIES];
  logic [IDW-1:0]        issue_ptr_q, commit_ptr_q;
  logic [IDW:0]          count_q;

  logic [IDW+1:0]        free_slots;
  logic [NR_ISSUE-1:0]   accept;
  logic [IDW-1:0]        aidx [NR_ISSUE];
  logic [IDW:0]          n_accept;
  logic [NR_ENTRIES-1:0] wb_hit, wb_ex_hit;
  logic [IDW-1:0]        cidx [NR_COMMIT];
  logic [NR_COMMIT-1:0]  retire;
  logic [IDW:0]          n_retire;
  logic                  acc_chain, vld_chain, ret_chain, eff_done, eff_ex;

  // Readiness uses only the registered count, so a same-cycle commit never frees issue space.
  always_comb begin
    free_slots = (IDW+2)'(NR_ENTRIES) - {1'b0, count_q};
    acc_chain  = 1'b1;
    n_accept   = '0;
    for (int i = 0; i < NR_ISSUE; i++) begin
      issue_ready_o[i]           = free_slots > (IDW+2)'(i);
      acc_chain                  = acc_chain & issue_valid_i[i] & issue_ready_o[i];
      accept[i]                  = acc_chain;
      n_accept                   = n_accept + (IDW+1)'(acc_chain);
      aidx[i]                    = issue_ptr_q + IDW'(i);
      issue_id_o[i*IDW +: IDW]   = aidx[i];
    end
  end

  // Several writeback ports may target one id; their exception flags are OR-ed.
  always_comb begin
    wb_hit    = '0;
    wb_ex_hit = '0;
    for (int e = 0; e < NR_ENTRIES; e++) begin
      for (int w = 0; w < NR_WB; w++) begin
        if (wb_valid_i[w] && wb_id_i[w*IDW +: IDW] == IDW'(e) && issued_q[e]) begin
          wb_hit[e]    = 1'b1;
          wb_ex_hit[e] = wb_ex_hit[e] | wb_ex_i[w];
        end
      end
    end
  end

  always_comb begin
    vld_chain = 1'b1;
    ret_chain = 1'b1;
    n_retire  = '0;
    eff_done  = 1'b0;
    eff_ex    = 1'b0;
    for (int k = 0; k < NR_COMMIT; k++) begin
      cidx[k] = commit_ptr_q + IDW'(k);
`ifdef MULTI_ISSUE_SB_WB_BYPASS_EN
      eff_done = done_q[cidx[k]] | wb_hit[cidx[k]];
      eff_ex   = ex_q[cidx[k]] | wb_ex_hit[cidx[k]];
`else
      eff_done = done_q[cidx[k]];
      eff_ex   = ex_q[cidx[k]];
`endif
      vld_chain                 = vld_chain & issued_q[cidx[k]] & eff_done;
      commit_valid_o[k]         = vld_chain;
      commit_ex_o[k]            = eff_ex;
      commit_id_o[k*IDW +: IDW] = cidx[k];
      commit_rd_o[k*5 +: 5]     = rd_q[cidx[k]];
      ret_chain                 = ret_chain & commit_ack_i[k] & vld_chain;
      retire[k]                 = ret_chain;
      n_retire                  = n_retire + (IDW+1)'(ret_chain);
    end
  end

  // Busy vector is derived from registered entry state only, never from this cycle's inputs.
  always_comb begin
    rd_busy_o = '0;
    for (int e = 0; e < NR_ENTRIES; e++) begin
      if (issued_q[e]) rd_busy_o[rd_q[e]] = 1'b1;
    end
    rd_busy_o[0] = 1'b0;
  end

  assign full_o  = (count_q == (IDW+1)'(NR_ENTRIES));
  assign count_o = count_q;

  // NOTE: sequential state uses non-blocking assignments only; later assignments in this
  // block (retire, then accept) intentionally override earlier ones for the same entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      issued_q     <= '0;
      done_q       <= '0;
      ex_q         <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      for (int e = 0; e < NR_ENTRIES; e++) begin
        if (wb_hit[e]) begin
          done_q[e] <= 1'b1;
          ex_q[e]   <= ex_q[e] | wb_ex_hit[e];
        end
      end
      for (int k = 0; k < NR_COMMIT; k++) begin
        if (retire[k]) begin
          issued_q[cidx[k]] <= 1'b0;
          done_q[cidx[k]]   <= 1'b0;
          ex_q[cidx[k]]     <= 1'b0;
        end
      end
      for (int i = 0; i < NR_ISSUE; i++) begin
        if (accept[i]) begin
          issued_q[aidx[i]] <= 1'b1;
          done_q[aidx[i]]   <= 1'b0;
          ex_q[aidx[i]]     <= 1'b0;
        end
      end
      issue_ptr_q  <= issue_ptr_q + n_accept[IDW-1:0];
      commit_ptr_q <= commit_ptr_q + n_retire[IDW-1:0];
      count_q      <= count_q + n_accept - n_retire;
    end
  end

  // NOTE: the destination-register array carries no reset; it is only meaningful while
  // the matching issued bit is set, and that bit is what reset clears.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      for (int i = 0; i < NR_ISSUE; i++) begin
        if (accept[i]) rd_q[aidx[i]] <= issue_rd_i[i*5 +: 5];
      end
    end
  end

endmodule

// File: tb/tb_multi_issue_scoreboard.sv
// Directed self-checking bench for multi_issue_scoreboard at default parameters.
// Expectations for the writeback bypass follow MULTI_ISSUE_SB_WB_BYPASS_EN when it is defined.
module tb_multi_issue_scoreboard;

  localparam int IDW = 3;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i;
  logic [1:0]  issue_valid_i;
  logic [9:0]  issue_rd_i;
  logic [1:0]  issue_ready_o;
  logic [5:0]  issue_id_o;
  logic [3:0]  wb_valid_i;
  logic [11:0] wb_id_i;
  logic [3:0]  wb_ex_i;
  logic [1:0]  commit_valid_o;
  logic [5:0]  commit_id_o;
  logic [9:0]  commit_rd_o;
  logic [1:0]  commit_ex_o;
  logic [1:0]  commit_ack_i;
  logic [31:0] rd_busy_o;
  logic        full_o;
  logic [3:0]  count_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  multi_issue_scoreboard dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
    .issue_ready_o(issue_ready_o), .issue_id_o(issue_id_o),
    .wb_valid_i(wb_valid_i), .wb_id_i(wb_id_i), .wb_ex_i(wb_ex_i),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o),
    .commit_rd_o(commit_rd_o), .commit_ex_o(commit_ex_o),
    .commit_ack_i(commit_ack_i), .rd_busy_o(rd_busy_o),
    .full_o(full_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i       = 1'b0;
    issue_valid_i = '0;
    issue_rd_i    = '0;
    wb_valid_i    = '0;
    wb_id_i       = '0;
    wb_ex_i       = '0;
    commit_ack_i  = '0;
  endtask

  task automatic set_wb(input int port, input logic [IDW-1:0] id, input logic ex);
    wb_valid_i[port]          = 1'b1;
    wb_id_i[port*IDW +: IDW]  = id;
    wb_ex_i[port]             = ex;
  endtask

  task automatic do_reset();
    idle();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    flush_i       = 1'b1;
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd2, 5'd1};
    cycle();
    rst_i = 1'b0;
    idle();
    #1;
    total_cnt++;
    if (issue_ready_o !== 2'b11) $display("FAIL reset_ready: got %b want 11", issue_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (commit_valid_o !== 2'b00 || rd_busy_o !== 32'h0 || full_o !== 1'b0)
      $display("FAIL reset_outputs: valid %b busy %h full %b want 00 0 0", commit_valid_o, rd_busy_o, full_o);
    else pass_cnt++;
    total_cnt++;
    if (count_o !== 4'd0 || issue_id_o !== 6'b001_000)
      $display("FAIL reset_count_ids: count %0d ids %b want 0 001000", count_o, issue_id_o);
    else pass_cnt++;
  endtask

  task automatic test_issue();
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd6, 5'd5};
    #1;
    total_cnt++;
    if (issue_id_o !== 6'b001_000) $display("FAIL issue_ids: got %b want 001000", issue_id_o);
    else pass_cnt++;
    cycle();
    idle();
    #1;
    total_cnt++;
    if (rd_busy_o !== 32'h0000_0060 || count_o !== 4'd2 || commit_valid_o !== 2'b00)
      $display("FAIL issue_state: busy %h count %0d valid %b want 00000060 2 00", rd_busy_o, count_o, commit_valid_o);
    else pass_cnt++;
    // Port 1 alone must not be accepted when port 0 is idle.
    issue_valid_i = 2'b10;
    issue_rd_i    = {5'd9, 5'd0};
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd2 || rd_busy_o !== 32'h0000_0060)
      $display("FAIL accept_chain: count %0d busy %h want 2 00000060", count_o, rd_busy_o);
    else pass_cnt++;
  endtask

  task automatic test_writeback_order();
    set_wb(0, 3'd1, 1'b0);
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b00) $display("FAIL wb_id1_only: valid %b want 00", commit_valid_o);
    else pass_cnt++;
    set_wb(1, 3'd0, 1'b0);
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b11 || commit_id_o !== 6'b001_000 || commit_rd_o !== {5'd6, 5'd5})
      $display("FAIL wb_both: valid %b id %b rd %b want 11 001000 0011000101", commit_valid_o, commit_id_o, commit_rd_o);
    else pass_cnt++;
    commit_ack_i = 2'b10;
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd2 || commit_valid_o !== 2'b11)
      $display("FAIL ack_port1_only: count %0d valid %b want 2 11", count_o, commit_valid_o);
    else pass_cnt++;
    commit_ack_i = 2'b01;
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd1 || commit_valid_o !== 2'b01 || commit_id_o[2:0] !== 3'd1 || rd_busy_o !== 32'h0000_0040)
      $display("FAIL ack_port0: count %0d valid %b id %0d busy %h want 1 01 1 00000040",
               count_o, commit_valid_o, commit_id_o[2:0], rd_busy_o);
    else pass_cnt++;
    commit_ack_i = 2'b01;
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd0 || rd_busy_o !== 32'h0)
      $display("FAIL drain: count %0d busy %h want 0 0", count_o, rd_busy_o);
    else pass_cnt++;
  endtask

  task automatic test_full();
    do_reset();
    issue_valid_i = 2'b11; issue_rd_i = {5'd2, 5'd1};
    cycle();
    issue_valid_i = 2'b11; issue_rd_i = {5'd4, 5'd3}; set_wb(0, 3'd0, 1'b0);
    cycle();
    idle();
    issue_valid_i = 2'b11; issue_rd_i = {5'd6, 5'd5};
    cycle();
    issue_valid_i = 2'b11; issue_rd_i = {5'd8, 5'd7};
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd8 || full_o !== 1'b1 || issue_ready_o !== 2'b00)
      $display("FAIL full_state: count %0d full %b ready %b want 8 1 00", count_o, full_o, issue_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (commit_valid_o !== 2'b01 || rd_busy_o !== 32'h0000_01FE)
      $display("FAIL full_busy: valid %b busy %h want 01 000001fe", commit_valid_o, rd_busy_o);
    else pass_cnt++;
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd11, 5'd11};
    commit_ack_i  = 2'b01;
    #1;
    total_cnt++;
    if (issue_ready_o !== 2'b00) $display("FAIL full_commit_same_cycle: ready %b want 00", issue_ready_o);
    else pass_cnt++;
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd7 || full_o !== 1'b0 || issue_ready_o !== 2'b01 || issue_id_o[2:0] !== 3'd0)
      $display("FAIL after_retire: count %0d full %b ready %b id %0d want 7 0 01 0",
               count_o, full_o, issue_ready_o, issue_id_o[2:0]);
    else pass_cnt++;
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd10, 5'd9};
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd8 || full_o !== 1'b1 || rd_busy_o !== 32'h0000_03FC)
      $display("FAIL refill_one: count %0d full %b busy %h want 8 1 000003fc", count_o, full_o, rd_busy_o);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      issue_valid_i = 2'b11; issue_rd_i = {5'd2, 5'd1};
      cycle();
    end
    issue_valid_i = 2'b01; issue_rd_i = {5'd0, 5'd3};
    cycle();
    idle();
    for (int p = 0; p < 4; p++) set_wb(p, 3'(p), 1'b0);
    cycle();
    idle();
    for (int p = 0; p < 3; p++) set_wb(p, 3'(p + 4), 1'b0);
    cycle();
    idle();
    for (int c = 0; c < 4; c++) begin
      commit_ack_i = 2'b11;
      cycle();
    end
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd0) $display("FAIL wrap_drain: count %0d want 0", count_o);
    else pass_cnt++;
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd11, 5'd10};
    #1;
    total_cnt++;
    if (issue_id_o !== 6'b000_111) $display("FAIL wrap_ids: got %b want 000111", issue_id_o);
    else pass_cnt++;
    cycle();
    idle();
    set_wb(0, 3'd0, 1'b0);
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b00) $display("FAIL wrap_order_wait: valid %b want 00", commit_valid_o);
    else pass_cnt++;
    set_wb(0, 3'd7, 1'b0);
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b11 || commit_id_o !== 6'b000_111 || commit_rd_o !== {5'd11, 5'd10})
      $display("FAIL wrap_commit: valid %b id %b rd %b want 11 000111 0101101010", commit_valid_o, commit_id_o, commit_rd_o);
    else pass_cnt++;
    commit_ack_i = 2'b11;
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd0 || commit_valid_o !== 2'b00)
      $display("FAIL wrap_retire: count %0d valid %b want 0 00", count_o, commit_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd4, 5'd3};
    cycle();
    idle();
    flush_i       = 1'b1;
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd8, 5'd7};
    set_wb(0, 3'd1, 1'b0);
    #1;
    total_cnt++;
    if (issue_ready_o !== 2'b11 || rd_busy_o !== 32'h0000_0018)
      $display("FAIL flush_not_gated: ready %b busy %h want 11 00000018", issue_ready_o, rd_busy_o);
    else pass_cnt++;
    cycle();
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd0 || rd_busy_o !== 32'h0 || issue_id_o !== 6'b001_000 || commit_valid_o !== 2'b00)
      $display("FAIL flush_result: count %0d busy %h ids %b valid %b want 0 0 001000 00",
               count_o, rd_busy_o, issue_id_o, commit_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_exception();
    issue_valid_i = 2'b01;
    issue_rd_i    = {5'd0, 5'd9};
    cycle();
    idle();
    set_wb(1, 3'd0, 1'b1);
    set_wb(3, 3'd0, 1'b1);
    #1;
    total_cnt++;
`ifdef MULTI_ISSUE_SB_WB_BYPASS_EN
    if (commit_valid_o !== 2'b01 || commit_ex_o[0] !== 1'b1)
      $display("FAIL ex_bypass: valid %b ex %b want 01 1", commit_valid_o, commit_ex_o[0]);
    else pass_cnt++;
`else
    if (commit_valid_o !== 2'b00) $display("FAIL ex_no_bypass: valid %b want 00", commit_valid_o);
    else pass_cnt++;
`endif
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b01 || commit_ex_o[0] !== 1'b1 || commit_rd_o[4:0] !== 5'd9)
      $display("FAIL ex_commit: valid %b ex %b rd %0d want 01 1 9", commit_valid_o, commit_ex_o[0], commit_rd_o[4:0]);
    else pass_cnt++;
    issue_valid_i = 2'b01;
    issue_rd_i    = {5'd0, 5'd12};
    cycle();
    idle();
    set_wb(0, 3'd1, 1'b0);
    set_wb(2, 3'd1, 1'b1);
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b11 || commit_ex_o !== 2'b11)
      $display("FAIL ex_or_ports: valid %b ex %b want 11 11", commit_valid_o, commit_ex_o);
    else pass_cnt++;
    commit_ack_i = 2'b11;
    cycle();
    idle();
    set_wb(0, 3'd2, 1'b1);
    cycle();
    idle();
    issue_valid_i = 2'b01;
    issue_rd_i    = {5'd0, 5'd13};
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b00 || count_o !== 4'd1 || commit_ex_o[0] !== 1'b0)
      $display("FAIL wb_not_issued_ignored: valid %b count %0d ex %b want 00 1 0",
               commit_valid_o, count_o, commit_ex_o[0]);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    issue_valid_i = 2'b11;
    issue_rd_i    = {5'd15, 5'd14};
    set_wb(0, 3'd2, 1'b0);
    cycle();
    idle();
    #1;
    total_cnt++;
    if (commit_valid_o !== 2'b01 || count_o !== 4'd3)
      $display("FAIL pre_reset: valid %b count %0d want 01 3", commit_valid_o, count_o);
    else pass_cnt++;
    rst_i        = 1'b1;
    commit_ack_i = 2'b11;
    cycle();
    rst_i = 1'b0;
    idle();
    #1;
    total_cnt++;
    if (count_o !== 4'd0 || commit_valid_o !== 2'b00 || rd_busy_o !== 32'h0 || issue_id_o !== 6'b001_000)
      $display("FAIL mid_reset: count %0d valid %b busy %h ids %b want 0 00 0 001000",
               count_o, commit_valid_o, rd_busy_o, issue_id_o);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_issue();
    test_writeback_order();
    test_full();
    test_wrap();
    test_flush();
    test_exception();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
